fsk_frame_ctrl: RTL

FSK_FRAME_CTRL -- requirements
Module: fsk_frame_ctrl

---
 rtl/fsk_frame_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fsk_frame_ctrl.sv
// FSK frame controller: pops bytes from the UART RX FIFO and sequences start/data/stop symbols.
// Optional even-parity symbol after the data bits when FSK_FRAME_PARITY_EN is defined.
module fsk_frame_ctrl #(
    parameter int SAMPLES_PER_BIT = 16,
    parameter int STOP_BITS       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       sample_tick,
    output logic       sym_bit,
    output logic       tx_active,
    output logic       frame_done,
    output logic [3:0] bit_idx
);

    localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef FSK_FRAME_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [3:0] FIRST_STOP_IDX = 4'd10;
`else
    localparam logic [3:0] FIRST_STOP_IDX = 4'd9;
`endif
    localparam logic [3:0] LAST_STOP_IDX = FIRST_STOP_IDX + 4'(STOP_BITS - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             sym_bit_q, sym_bit_d;
    logic             tx_active_q, tx_active_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
`ifdef FSK_FRAME_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic sym_end;
    logic load;
    logic rd_uart_c;
    logic frame_done_c;

    // Ticks only advance the counter outside IDLE, so the clk that leaves IDLE never counts.
    assign sym_end = (state_q != ST_IDLE) && sample_tick && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        sym_bit_d    = sym_bit_q;
        tx_active_d  = tx_active_q;
        bit_idx_d    = bit_idx_q;
`ifdef FSK_FRAME_PARITY_EN
        parity_d     = parity_q;
`endif
        load         = 1'b0;
        frame_done_c = 1'b0;

        if (state_q == ST_IDLE)
            cnt_d = '0;
        else if (sample_tick)
            cnt_d = sym_end ? '0 : cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!rx_empty)
                    load = 1'b1;
            end
            ST_START: begin
                if (sym_end) begin
                    state_d   = ST_DATA;
                    sym_bit_d = shift_q[0];
                    bit_idx_d = 4'd1;
                end
            end
            ST_DATA: begin
                if (sym_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd8) begin
`ifdef FSK_FRAME_PARITY_EN
                        state_d   = ST_PARITY;
                        sym_bit_d = parity_q;
`else
                        state_d   = ST_STOP;
                        sym_bit_d = 1'b1;
`endif
                    end else begin
                        sym_bit_d = shift_q[1];
                    end
                end
            end
`ifdef FSK_FRAME_PARITY_EN
            ST_PARITY: begin
                if (sym_end) begin
                    state_d   = ST_STOP;
                    sym_bit_d = 1'b1;
                    bit_idx_d = bit_idx_q + 4'd1;
                end
            end
`endif
            ST_STOP: begin
                if (sym_end) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == LAST_STOP_IDX) begin
                        frame_done_c = 1'b1;
                        // Chain straight into the next frame when a byte is waiting.
                        if (!rx_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d     = ST_IDLE;
                            tx_active_d = 1'b0;
                            bit_idx_d   = 4'd0;
                        end
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                sym_bit_d   = 1'b1;
                tx_active_d = 1'b0;
                bit_idx_d   = 4'd0;
            end
        endcase

        rd_uart_c = load;
        if (load) begin
            state_d     = ST_START;
            shift_d     = r_data;
            sym_bit_d   = 1'b0;
            tx_active_d = 1'b1;
            bit_idx_d   = 4'd0;
`ifdef FSK_FRAME_PARITY_EN
            parity_d    = ^r_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= 8'h00;
            sym_bit_q   <= 1'b1;
            tx_active_q <= 1'b0;
            bit_idx_q   <= 4'd0;
`ifdef FSK_FRAME_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            sym_bit_q   <= sym_bit_d;
            tx_active_q <= tx_active_d;
            bit_idx_q   <= bit_idx_d;
`ifdef FSK_FRAME_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Strobes are suppressed while reset is held so no byte is popped or reported.
    assign rd_uart    = rd_uart_c & reset;
    assign frame_done = frame_done_c & reset;
    assign sym_bit    = sym_bit_q;
    assign tx_active  = tx_active_q;
    assign bit_idx    = bit_idx_q;

endmodule
